// File: rtl/monolith_job_driver.sv
// monolith_job_driver: sequences Monolith hash-engine jobs between a request and a response channel; MONOLITH_DRV_TIMEOUT_EN adds a RUN timeout abort
module monolith_job_driver #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [30:0]      req_in1,
  input  logic [30:0]      req_in2,
  input  logic             req_mode,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [30:0]      rsp_data,
  output logic             rsp_err,
  output logic [30:0]      eng_in1,
  output logic [30:0]      eng_in2,
  output logic             eng_mode,
  output logic             eng_go,
  input  logic [30:0]      eng_out,
  input  logic             eng_valid,
  output logic             busy,
  output logic [CNT_W-1:0] job_count
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
  state_t state, state_nx;
  logic done, tmo;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == RUN && eng_valid;
`ifdef MONOLITH_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] run_cnt;
  logic err_q;
  assign tmo = state == RUN && !eng_valid && run_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign rsp_err = err_q;
  // count RUN cycles from a clean start on every LOAD
  always_ff @(posedge clk)
    if (reset || state == LOAD) run_cnt <= '0;
    else if (state == RUN) run_cnt <= run_cnt + 1'b1;
  // error flag set by a timeout abort, cleared by a real engine result
  always_ff @(posedge clk)
    if (reset || done) err_q <= 1'b0;
    else if (tmo) err_q <= 1'b1;
`else
  assign tmo = 1'b0;
  assign rsp_err = 1'b0;
`endif
  // job state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = req_valid ? LOAD : IDLE;
      LOAD: state_nx = RUN;
      RUN:  state_nx = (done || tmo) ? RESP : RUN;
      RESP: state_nx = rsp_ready ? IDLE : RESP;
    endcase
  end
  // registered engine pins, response and job counter
  always_ff @(posedge clk)
    if (reset) begin
      eng_in1   <= '0;
      eng_in2   <= '0;
      eng_mode  <= 1'b0;
      eng_go    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      job_count <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        eng_in1  <= req_in1;
        eng_in2  <= req_mode ? req_in2 : '0;
        eng_mode <= req_mode;
      end
      eng_go    <= state_nx == RUN;
      rsp_valid <= state_nx == RESP;
      if (done) rsp_data <= eng_out;
      else if (tmo) rsp_data <= '0;
      if (state == RESP && rsp_ready) job_count <= job_count + 1'b1;
    end
endmodule

// File: tb/tb_monolith_job_driver.sv
// tb_monolith_job_driver: vector table plus scoreboard bench for monolith_job_driver with an XOR stub engine
module tb_monolith_job_driver;
`ifdef MONOLITH_DRV_TIMEOUT_EN
  localparam int to_cycles = 8;
`else
  localparam int to_cycles = 1024;
`endif
  logic clk = 0, reset = 1, req_valid = 0, req_mode = 0, rsp_ready = 0;
  logic [30:0] req_in1 = 0, req_in2 = 0;
  logic req_ready, rsp_valid, rsp_err, eng_mode, eng_go, eng_valid, busy;
  logic [30:0] rsp_data, eng_in1, eng_in2, eng_out;
  logic [2:0] job_count;
  logic stub_en = 1, stray = 0;
  logic [7:0] sc = 0;
  int n_chk = 0, n_fail = 0, exp_cnt = 0, lc = 0, lo = 0, last_lat = 0;
  logic b1 = 0, b2 = 0, pv = 0, pg = 0, seen = 0;
  logic [31:0] q[$];
  logic [31:0] e;

  typedef struct {
    logic [30:0] in1;
    logic [30:0] in2;
    logic mode;
    int stall;
    logic [30:0] exp;
  } vec_t;
  vec_t v[6];

  monolith_job_driver #(.TIMEOUT_CYCLES(to_cycles), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_mode(req_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .eng_in1(eng_in1), .eng_in2(eng_in2), .eng_mode(eng_mode), .eng_go(eng_go),
    .eng_out(eng_out), .eng_valid(eng_valid), .busy(busy), .job_count(job_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) sc <= eng_go ? sc + 8'd1 : 8'd0;
  assign eng_valid = stray | (stub_en & eng_go & (sc == 8'd5));
  assign eng_out = eng_in1 ^ eng_in2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic cond(input int sel);
    return sel == 0 ? (req_valid && req_ready) : sel == 1 ? rsp_valid : (rsp_valid && rsp_ready);
  endfunction

  task automatic wait_for(input int sel, input string nm);
    logic ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      ok = cond(sel);
    end
    if (!ok) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic run(input vec_t x, input bit hold);
    req_in1 = x.in1; req_in2 = x.in2; req_mode = x.mode; req_valid = 1;
    rsp_ready = x.stall == 0;
    wait_for(0, "accept");
    q.push_back({1'b0, x.exp});
    @(posedge clk); #1;
    if (!hold) req_valid = 0;
    if (x.stall > 0) begin
      wait_for(1, "rsp_valid");
      for (int s = 0; s < x.stall; s++) begin
        @(negedge clk);
        chk("stall_valid", rsp_valid, 1);
        chk("stall_data", rsp_data, x.exp);
        chk("stall_go", eng_go, 0);
        chk("stall_req_ready", req_ready, 0);
      end
      @(posedge clk); #1 rsp_ready = 1;
    end
    wait_for(2, "handshake");
    @(posedge clk); #1;
    exp_cnt++;
    chk("job_count", job_count, exp_cnt % 8);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      lc = 0; lo = 0; b1 = 0; b2 = 0; pv = 0; pg = 0;
    end else begin
      if (eng_go && !pg) begin
        chk("load_1cyc", {30'b0, b2, b1}, 32'd1);
        if (seen) chk("go_gap", lo >= 2, 1);
        if (!eng_mode) chk("in2_zero", eng_in2, 0);
        seen = 1; lc = 1;
      end else if (lc != 0 && !rsp_valid) lc++;
      lo = eng_go ? 0 : lo + 1;
      if (rsp_valid && !pv) begin
        last_lat = lc;
        if (stub_en) chk("rsp_lat", lc, 6);
        lc = 0;
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) chk("rsp_extra", 1, 0);
        else begin
          e = q.pop_front();
          chk("rsp", {rsp_err, rsp_data}, e);
        end
      end
      b2 = b1; b1 = busy; pv = rsp_valid; pg = eng_go;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    v[0] = '{31'h0000_0001, 31'h7FFF_FFFF, 1'b0, 0, 31'h0000_0001};
    v[1] = '{31'h1234_5678, 31'h0F0F_0F0F, 1'b1, 0, 31'h1D3B_5977};
    v[2] = '{31'h7FFF_FFFF, 31'h5555_5555, 1'b1, 10, 31'h2AAA_AAAA};
    v[3] = '{31'h0ABC_DEF0, 31'h7FFF_FFFF, 1'b0, 3, 31'h0ABC_DEF0};
    v[4] = '{31'h7FFF_FFFF, 31'h7FFF_FFFF, 1'b1, 0, 31'h0000_0000};
    v[5] = '{31'h3333_3333, 31'h0000_0000, 1'b1, 1, 31'h3333_3333};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_eng", {eng_go, eng_mode, eng_in1 | eng_in2}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", job_count, 0);
    @(posedge clk); #1 reset = 0;
    stray = 1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_busy", busy, 0);
      chk("stray_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1 stray = 0;
    req_in1 = 31'h0000_00AA; req_in2 = 0; req_mode = 0; req_valid = 1; rsp_ready = 1;
    wait_for(0, "accept_rst");
    @(posedge clk); #1 req_valid = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("midrun_go_before_edge", eng_go, 1);
    @(negedge clk);
    chk("midrun_go", eng_go, 0);
    chk("midrun_rsp", rsp_valid, 0);
    chk("midrun_count", job_count, 0);
    chk("midrun_req_ready", req_ready, 1);
    @(posedge clk); #1 reset = 0;
    stub_en = 0;
    req_in1 = 31'h0000_0055; req_valid = 1;
    wait_for(0, "accept_to");
`ifdef MONOLITH_DRV_TIMEOUT_EN
    q.push_back({1'b1, 31'h0});
    @(posedge clk); #1 req_valid = 0;
    wait_for(2, "to_handshake");
    chk("to_run_cycles", last_lat, 8);
    @(posedge clk); #1;
    exp_cnt++;
    chk("to_count", job_count, exp_cnt % 8);
`else
    @(posedge clk); #1 req_valid = 0;
    repeat (100) @(negedge clk);
    chk("noto_busy", busy, 1);
    chk("noto_go", eng_go, 1);
    chk("noto_rsp", rsp_valid, 0);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
`endif
    stub_en = 1;
    for (int i = 0; i < 6; i++) run(v[i], i != 5);
    for (int j = 0; j < 3; j++) run('{31'(j + 1), 31'h7000_0000, 1'b0, 0, 31'(j + 1)}, 0);
    repeat (3) @(negedge clk);
    chk("end_queue_empty", q.size(), 0);
    chk("end_idle", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
